// File: rtl/demodulator.sv
// Differential spread-spectrum demodulator: each bit is sf reference chips then sf data chips,
// decided by majority agreement, shifted MSB-first into an MSG_W-bit message word.
module demodulator #(
    parameter int MSG_W  = 32,
    parameter int SF_MAX = 64
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic                         i_chip,
    input  logic                         i_chip_valid,
    input  logic [$clog2(SF_MAX+1)-1:0]  i_sf,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_bit,
    output logic                         o_bit_valid,
    output logic [MSG_W-1:0]             o_msg,
    output logic                         o_msg_valid
);

    localparam int SFW  = $clog2(SF_MAX + 1);
    localparam int IDXW = (SF_MAX > 1) ? $clog2(SF_MAX) : 1;
    localparam int BCW  = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [SFW-1:0] SF_MAX_C = SFW'(SF_MAX);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(MSG_W - 1);

    typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

    state_t            state_q;
    logic [SFW-1:0]    sf_q;
    logic [SFW-1:0]    idx_q;
    logic [SFW-1:0]    match_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [MSG_W-1:0]  shreg_q;
    logic              bit_q;
    logic              bit_valid_q;
    logic [MSG_W-1:0]  msg_q;
    logic              msg_valid_q;
    logic              ref_buf_q [SF_MAX];

    logic              last_chip;
    logic              chip_match;
    logic [SFW-1:0]    match_d;
    logic              bit_d;
    logic [MSG_W-1:0]  shreg_d;

    // match_d never exceeds sf, so it fits; the doubled compare uses one extra bit.
    always_comb begin
        last_chip  = (idx_q == (sf_q - SFW'(1)));
        chip_match = (i_chip == ref_buf_q[idx_q[IDXW-1:0]]);
        match_d    = match_q + SFW'(chip_match);
        bit_d      = ({match_d, 1'b0} > {1'b0, sf_q});
        shreg_d    = (shreg_q << 1) | MSG_W'(bit_d);
    end

    always_ff @(posedge i_clk) begin
        if (state_q == REF && i_chip_valid) begin
            ref_buf_q[idx_q[IDXW-1:0]] <= i_chip;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= IDLE;
            sf_q        <= '0;
            idx_q       <= '0;
            match_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            msg_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && i_sf != '0) begin
                        sf_q      <= (i_sf > SF_MAX_C) ? SF_MAX_C : i_sf;
                        idx_q     <= '0;
                        match_q   <= '0;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        state_q   <= REF;
                    end
                end
                REF: begin
                    if (i_chip_valid) begin
                        if (last_chip) begin
                            idx_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            idx_q <= idx_q + SFW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_chip_valid) begin
                        if (last_chip) begin
                            bit_q       <= bit_d;
                            bit_valid_q <= 1'b1;
                            shreg_q     <= shreg_d;
                            match_q     <= '0;
                            idx_q       <= '0;
                            if (bit_cnt_q == LAST_BIT) begin
                                msg_q       <= shreg_d;
                                msg_valid_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BCW'(1);
                                state_q   <= REF;
                            end
                        end else begin
                            match_q <= match_d;
                            idx_q   <= idx_q + SFW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_msg       = msg_q;
    assign o_msg_valid = msg_valid_q;

endmodule
